// File: rtl/mem_if.sv
// Request/response bus for multi_port_mem: NCH requester channels share one
// memory. Handshake semantics (both directions): a transfer happens on the
// rising clk edge where valid and ready of the same channel are both high.
// The requester holds req_* stable while req_valid is high and not yet
// accepted; the memory holds resp_* stable while resp_valid is high and
// resp_ready of that channel is low.
interface mem_if #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NCH-1:0]          req_valid;
  logic [NCH-1:0]          req_ready;
  logic [NCH*ADDR_W-1:0]   req_addr;
  logic [NCH-1:0]          req_wen;
  logic [NCH*DATA_W-1:0]   req_wdata;
  logic [NCH*DATA_W/8-1:0] req_wmask;
  logic [NCH-1:0]          resp_valid;
  logic [NCH-1:0]          resp_ready;
  logic [DATA_W-1:0]       resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/multi_port_mem.sv
// Single-ported word memory shared by NCH requesters through a round-robin
// arbiter. One transaction is in flight at a time: IDLE accepts, WAIT burns
// the remaining latency, RESP presents the response until it is consumed.
module multi_port_mem #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_if.slave       bus,
  output logic [1:0] dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int SHIFT = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = $clog2(NCH);
  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gnt;
  logic [CNT_W-1:0]  cnt;
  logic [NCH-1:0]    resp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Storage is deliberately left out of reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              found;
  logic [PTR_W-1:0]  win;
  logic [NCH-1:0]    win_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wen;
  logic [DATA_W-1:0] sel_wdata;
  logic [NB-1:0]     sel_wmask;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              sel_err;
  logic              accept;

  // Round-robin search: first valid channel at or above the priority pointer
  always_comb begin
    int c;
    c      = 0;
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int k = 0; k < NCH; k++) begin
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!found && bus.req_valid[c]) begin
        found = 1'b1;
        win   = PTR_W'(c);
      end
    end
    if (found) win_oh[win] = 1'b1;
  end

  assign sel_addr  = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign sel_wen   = bus.req_wen[win];
  assign sel_wdata = bus.req_wdata[int'(win)*DATA_W +: DATA_W];
  assign sel_wmask = bus.req_wmask[int'(win)*NB +: NB];

  // Misaligned addresses and words past the end of the array are both errors.
  assign word_idx = sel_addr >> SHIFT;
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign sel_err  = (|(sel_addr & ADDR_W'(NB - 1))) || (word_idx >= ADDR_W'(DEPTH));

  // Reset masks the grant so nothing is accepted (or written) while rst is high.
  assign accept        = (state == IDLE) && found && !rst;
  assign bus.req_ready = accept ? win_oh : '0;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_state      = state;

  // Byte-masked array write on the acceptance edge of an error-free write
  always_ff @(posedge clk) begin
    if (accept && sel_wen && !sel_err) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_wmask[b]) mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // Transaction FSM: accept, count out the latency, hold the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt          <= '0;
      cnt          <= '0;
      resp_valid_q <= '0;
      rdata_q      <= '0;
      err_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt     <= win;
            ptr     <= (int'(win) == NCH - 1) ? '0 : win + 1'b1;
            err_q   <= sel_err;
            rdata_q <= (!sel_wen && !sel_err) ? mem[mem_idx] : '0;
            if (LAT == 1) begin
              state        <= RESP;
              resp_valid_q <= win_oh;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LAT - 1);
            end
          end
        end
        WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            state        <= RESP;
            cnt          <= '0;
            resp_valid_q <= NCH'(1) << gnt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // Only the granted channel's resp_ready completes the transfer.
          if (bus.resp_ready[gnt]) begin
            state        <= IDLE;
            resp_valid_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_port_mem.sv
// Directed and randomized bench for multi_port_mem with a word-level
// reference memory and a round-robin pointer model.
module tb_multi_port_mem;
  localparam int NCH    = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 2;
  localparam int NB     = DATA_W / 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_if #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [1:0] dbg_state;

  multi_port_mem #(
    .NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [DATA_W-1:0] ref_mem [longint];
  int                ref_ptr;

  // Per-channel request fields
  logic              op_wen   [NCH];
  logic [ADDR_W-1:0] op_addr  [NCH];
  logic [DATA_W-1:0] op_wdata [NCH];
  logic [NB-1:0]     op_wmask [NCH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int c, input logic wen, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [NB-1:0] wmask);
    op_wen[c]   = wen;
    op_addr[c]  = addr;
    op_wdata[c] = wdata;
    op_wmask[c] = wmask;
  endtask

  task automatic drive_ops(input logic [NCH-1:0] vmask);
    for (int c = 0; c < NCH; c++) begin
      bus.req_valid[c]                 = vmask[c];
      bus.req_wen[c]                   = op_wen[c];
      bus.req_addr[c*ADDR_W +: ADDR_W] = op_addr[c];
      bus.req_wdata[c*DATA_W +: DATA_W] = op_wdata[c];
      bus.req_wmask[c*NB +: NB]        = op_wmask[c];
    end
  endtask

  function automatic int exp_winner(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) begin
      if (v[(ref_ptr + k) % NCH]) return (ref_ptr + k) % NCH;
    end
    return -1;
  endfunction

  // Apply channel c's request to the reference memory; return expected response.
  task automatic model_apply(input int c, output logic [DATA_W-1:0] rd, output logic er);
    logic [ADDR_W-1:0] a;
    longint            w;
    logic [DATA_W-1:0] word;
    a  = op_addr[c];
    w  = longint'(a / NB);
    er = ((a % NB) != 0) || (w >= DEPTH);
    rd = '0;
    if (!er) begin
      word = ref_mem.exists(w) ? ref_mem[w] : '0;
      if (op_wen[c]) begin
        for (int b = 0; b < NB; b++)
          if (op_wmask[c][b]) word[b*8 +: 8] = op_wdata[c][b*8 +: 8];
        ref_mem[w] = word;
      end else begin
        rd = word;
      end
    end
  endtask

  // Driver: present requests, check arbitration, latency, response and its hold.
  task automatic run_txn(input logic [NCH-1:0] vmask, input int hold,
                         output logic [DATA_W-1:0] rd, output logic er);
    int g, exp_g, lat, n;
    logic [DATA_W-1:0] erd;
    logic eer;
    logic [NCH-1:0] oh;
    rd = '0;
    er = 1'b0;
    drive_ops(vmask);
    bus.resp_ready = '0;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    exp_g = exp_winner(vmask);
    g = -1;
    for (int c = 0; c < NCH; c++) if (bus.req_ready[c]) g = c;
    check("grant", g, exp_g);
    check("req_ready_onehot", $countones(bus.req_ready), 1);
    if (g < 0) begin
      bus.req_valid = '0;
      return;
    end
    ref_ptr = (g + 1) % NCH;
    model_apply(g, erd, eer);
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    while (!bus.resp_valid[g] && lat < 20) begin
      @(negedge clk); lat++;
    end
    oh = '0;
    oh[g] = 1'b1;
    check("latency", lat, LAT);
    check("resp_valid_onehot", bus.resp_valid, oh);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    check("rdata", rd, erd);
    check("err", er, eer);
    for (int h = 0; h < hold; h++) begin
      bus.resp_ready = ~oh;
      bus.req_valid  = '1;
      @(negedge clk);
      check("hold_resp_valid", bus.resp_valid, oh);
      check("hold_rdata", bus.resp_rdata, rd);
      check("hold_err", bus.resp_err, er);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.req_valid  = '0;
    bus.resp_ready = oh;
    @(negedge clk);
    bus.resp_ready = '0;
    check("resp_done", bus.resp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic er;
    int ng, cyc, g, sel;
    logic [ADDR_W-1:0] a;

    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_wen    = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = '0;
    for (int c = 0; c < NCH; c++) set_op(c, 1'b0, '0, '0, '0);
    ref_ptr = 0;

    // Reset state, with requests pending
    repeat (2) @(negedge clk);
    bus.req_valid = '1;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_err", bus.resp_err, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Both channels valid continuously: grants alternate from ch0
    set_op(0, 1'b0, 32'h10, '0, '0);
    set_op(1, 1'b0, 32'h14, '0, '0);
    drive_ops(2'b11);
    bus.resp_ready = '1;
    ng = 0;
    cyc = 0;
    while (ng < 6 && cyc < 200) begin
      #1;
      if (bus.req_ready != '0) begin
        g = bus.req_ready[1] ? 1 : 0;
        check("rr_alternate", g, ng % 2);
        ng++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rr_grant_count", ng, 6);
    bus.req_valid = '0;
    repeat (LAT + 3) @(negedge clk);
    bus.resp_ready = '0;
    check("rr_drained", bus.resp_valid, 0);
    ref_ptr = 0;

    // Write then read back, full mask
    set_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    run_txn(2'b01, 0, rd, er);
    check("wr_rdata_zero", rd, 0);
    set_op(0, 1'b0, 32'h10, '0, '0);
    run_txn(2'b01, 0, rd, er);
    check("rd_deadbeef", rd, 32'hDEADBEEF);
    check("rd_deadbeef_err", er, 0);

    // Partial byte mask merge
    set_op(1, 1'b1, 32'h20, 32'h11223344, 4'hF);
    run_txn(2'b10, 0, rd, er);
    set_op(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
    run_txn(2'b01, 0, rd, er);
    set_op(1, 1'b0, 32'h20, '0, '0);
    run_txn(2'b10, 0, rd, er);
    check("mask_merge", rd, 32'h11BB33DD);

    // Error cases: misaligned, out of range, and writes that must not land
    set_op(0, 1'b0, 32'h13, '0, '0);
    run_txn(2'b01, 0, rd, er);
    check("misaligned_err", er, 1);
    check("misaligned_rdata", rd, 0);
    set_op(1, 1'b0, DEPTH * NB, '0, '0);
    run_txn(2'b10, 0, rd, er);
    check("range_err", er, 1);
    check("range_rdata", rd, 0);
    set_op(0, 1'b1, 32'h21, 32'hFFFFFFFF, 4'hF);
    run_txn(2'b01, 0, rd, er);
    check("misaligned_wr_err", er, 1);
    set_op(1, 1'b0, 32'h20, '0, '0);
    run_txn(2'b10, 0, rd, er);
    check("after_err_unchanged", rd, 32'h11BB33DD);

    // Response held for 5 cycles with resp_ready low on the granted channel
    set_op(0, 1'b0, 32'h10, '0, '0);
    run_txn(2'b01, 5, rd, er);
    check("hold_read_value", rd, 32'hDEADBEEF);

    // Reset in WAIT of a write: write persists, pointer returns to ch0
    set_op(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    drive_ops(2'b01);
    #1;
    check("rstwait_grant", bus.req_ready, 2'b01);
    model_apply(0, rd, er);
    @(negedge clk);
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    check("rstwait_req_ready", bus.req_ready, 0);
    check("rstwait_resp_valid", bus.resp_valid, 0);
    check("rstwait_rdata", bus.resp_rdata, 0);
    check("rstwait_err", bus.resp_err, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = 0;
    repeat (LAT + 2) @(negedge clk);
    check("rstwait_no_resp", bus.resp_valid, 0);
    set_op(0, 1'b0, 32'h40, '0, '0);
    set_op(1, 1'b0, 32'h10, '0, '0);
    run_txn(2'b11, 0, rd, er);
    check("rstwait_readback", rd, 32'hCAFEF00D);

    // Randomized traffic over a small prewritten window
    for (int k = 0; k < 16; k++) begin
      set_op(k % NCH, 1'b1, 32'h100 + k * NB, $urandom, 4'hF);
      run_txn(NCH'(1) << (k % NCH), 0, rd, er);
    end
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < NCH; c++) begin
        sel = $urandom_range(0, 7);
        a = 32'h100 + $urandom_range(0, 15) * NB;
        if (sel == 0) a = a + $urandom_range(1, NB - 1);
        else if (sel == 1) a = DEPTH * NB + $urandom_range(0, 15) * NB;
        set_op(c, $urandom_range(0, 1), a, $urandom, NB'($urandom_range(0, 15)));
      end
      run_txn(NCH'($urandom_range(1, 3)), $urandom_range(0, 2), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_port_mem.md
MULTI_PORT_MEM -- requirements
Module: multi_port_mem

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requester channels (>=2).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter DATA_W, default 32, word width (multiple of 8).
REQ-004 SHALL have parameter DEPTH, default 1024, number of words (power of 2).
REQ-005 SHALL have parameter LAT, default 2, cycles from acceptance to response (>=1).
REQ-006 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port req_valid  in  NCH  per-channel request valid.
REQ-009 SHALL have port req_ready  out  NCH  per-channel request accepted.
REQ-010 SHALL have port req_addr  in  NCH*ADDR_W  byte addresses, channel i at slice i.
REQ-011 SHALL have port req_wen  in  NCH  1 = write, 0 = read.
REQ-012 SHALL have port req_wdata  in  NCH*DATA_W  write data.
REQ-013 SHALL have port req_wmask  in  NCH*DATA_W/8  byte write strobes.
REQ-014 SHALL have port resp_valid  out  NCH  per-channel response valid.
REQ-015 SHALL have port resp_ready  in  NCH  per-channel response consumed.
REQ-016 SHALL have port resp_rdata  out  DATA_W  read data, shared by all channels.
REQ-017 SHALL have port resp_err  out  1  error flag for the current response.

Function
REQ-018 SHALL hold DEPTH x DATA_W words internally; the array is not reset.
REQ-019 SHALL have a 3-state FSM (IDLE, WAIT, RESP) with at most one outstanding transaction.
REQ-020 In IDLE, SHALL assert req_ready only for the round-robin winner among valid channels, searching from the priority pointer upward modulo NCH.
REQ-021 SHALL accept a request on the edge where req_valid[i] & req_ready[i]; that edge updates the pointer to (i+1) mod NCH.
REQ-022 SHALL hold req_ready all-zero in WAIT and RESP; in IDLE with no req_valid, req_ready SHALL be all-zero.
REQ-023 SHALL compute word index = addr >> log2(DATA_W/8).
REQ-024 SHALL flag an error if addr is misaligned (low log2(DATA_W/8) bits nonzero) or index >= DEPTH.
REQ-025 On an accepted write without error, SHALL update only the mask-enabled bytes on the acceptance edge.
REQ-026 On an accepted read without error, SHALL capture the word on the acceptance edge.
REQ-027 On error, SHALL perform no write, return resp_rdata = 0 and resp_err = 1.
REQ-028 Write responses SHALL return resp_rdata = 0.
REQ-029 After acceptance: LAT=1 -> RESP directly; LAT>1 -> WAIT with down-counter loaded with LAT-1, entering RESP when it expires, so resp_valid first rises exactly LAT cycles after acceptance.
REQ-030 In RESP, SHALL assert resp_valid only for the granted channel, holding rdata/err stable until resp_ready of that channel is high.
REQ-031 The resp_valid & resp_ready edge SHALL return the FSM to IDLE; the next acceptance is possible on the following edge (minimum 1 idle cycle).
REQ-032 resp_ready on non-granted channels SHALL be ignored; req_valid dropping during WAIT/RESP SHALL NOT affect the transaction.
REQ-033 SHALL not starve a channel: with all channels continuously valid, each channel is granted once every NCH transactions.

Reset
REQ-034 While rst is high, SHALL force FSM = IDLE, pointer = 0, counter = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-035 Reset during WAIT/RESP SHALL drop the response; a write committed on an earlier edge SHALL remain in the array.

Verification
REQ-036 LAT=2, ch0 writes 0xDEADBEEF to 0x10 with mask 0xF, then reads 0x10 -> each resp_valid rises 2 cycles after acceptance; read returns 0xDEADBEEF, err = 0.
REQ-037 Write 0x11223344 to 0x20 with mask 0xF, then write 0xAABBCCDD with mask 0x5, then read -> 0x11BB33DD.
REQ-038 ch0 and ch1 valid every cycle from reset, resp_ready = 1 -> grants alternate 0,1,0,1, starting with ch0.
REQ-039 Read 0x13 (misaligned) and read DEPTH*4 -> resp_err = 1, rdata = 0; a subsequent read of the prior target word is unchanged.
REQ-040 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid and rdata stay constant, req_ready stays 0 for all channels.
REQ-041 Assert rst during WAIT of a write -> all outputs 0 immediately; after release, a read returns the written data and ch0 has priority.
